mask_serializer_ctrl: RTL and testbench

Sequencer for the mask serializer datapath. It accepts a frame-start command and a resolution code, then pulls one mask row per handshake from the upstream row buffer and pulses the serializer's load strobe. It paces the serializer's next strobe with downstream backpressure, counts beats and rows, and cross-checks the serializer's done flag. It sits between the mask row buffer, the serializer and the downstream mask consumer.

---
 rtl/mask_pkg.sv | 30 +++
 rtl/mask_res_decode.sv | 48 ++++
 rtl/mask_serializer_ctrl.sv | 135 +++++++++++++
 tb/tb_mask_serializer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_pkg.sv
// Shared definitions for the mask serializer: resolution codes, controller
// states and the default per-resolution beat/row counts.
package mask_pkg;

    typedef enum logic [1:0] {
        RES_320  = 2'b00,
        RES_640  = 2'b01,
        RES_1080 = 2'b10,
        RES_BAD  = 2'b11
    } res_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ROW  = 3'd1,
        STREAM    = 3'd2,
        ROW_END   = 3'd3,
        FRAME_END = 3'd4
    } state_e;

    localparam int STEPS_320  = 16;
    localparam int STEPS_640  = 32;
    localparam int STEPS_1080 = 54;
    localparam int ROWS_320   = 240;
    localparam int ROWS_640   = 480;
    localparam int ROWS_1080  = 1080;

    // Wide enough for the largest beats-per-row value.
    localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/mask_res_decode.sv
// Combinational map from resolution code to beats per row, rows per frame
// and a legality bit.
module mask_res_decode
    import mask_pkg::*;
#(
    parameter int STEPS_SEL0 = STEPS_320,
    parameter int STEPS_SEL1 = STEPS_640,
    parameter int STEPS_SEL2 = STEPS_1080,
    parameter int ROWS_SEL0  = ROWS_320,
    parameter int ROWS_SEL1  = ROWS_640,
    parameter int ROWS_SEL2  = ROWS_1080,
    parameter int ROW_CNT_W  = 11
) (
    input  logic [1:0]            i_res,
    output logic [BEAT_CNT_W-1:0] o_steps,
    output logic [ROW_CNT_W-1:0]  o_rows,
    output logic                  o_legal
);

    always_comb begin
        o_steps = '0;
        o_rows  = '0;
        o_legal = 1'b0;
        case (i_res)
            RES_320: begin
                o_steps = BEAT_CNT_W'(STEPS_SEL0);
                o_rows  = ROW_CNT_W'(ROWS_SEL0);
                o_legal = 1'b1;
            end
            RES_640: begin
                o_steps = BEAT_CNT_W'(STEPS_SEL1);
                o_rows  = ROW_CNT_W'(ROWS_SEL1);
                o_legal = 1'b1;
            end
            RES_1080: begin
                o_steps = BEAT_CNT_W'(STEPS_SEL2);
                o_rows  = ROW_CNT_W'(ROWS_SEL2);
                o_legal = 1'b1;
            end
            default: begin
                o_steps = '0;
                o_rows  = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mask_serializer_ctrl.sv
// Frame sequencer for the mask serializer: row handshakes, load/next strobes
// paced by downstream backpressure, beat/row counting and done cross-check.
module mask_serializer_ctrl
    import mask_pkg::*;
#(
    parameter int STEPS_SEL0 = STEPS_320,
    parameter int STEPS_SEL1 = STEPS_640,
    parameter int STEPS_SEL2 = STEPS_1080,
    parameter int ROWS_SEL0  = ROWS_320,
    parameter int ROWS_SEL1  = ROWS_640,
    parameter int ROWS_SEL2  = ROWS_1080,
    parameter int ROW_CNT_W  = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] res_in,
    input  logic       abort,
    input  logic       row_valid,
    output logic       row_ready,
    output logic       ser_load,
    output logic       ser_next,
    output logic [1:0] ser_res,
    input  logic       ser_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    state_e                r_state;
    logic [1:0]            r_res_q;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [ROW_CNT_W-1:0]  r_row_cnt;
    logic                  r_err;

    logic [1:0]            w_res_sel;
    logic [BEAT_CNT_W-1:0] w_steps;
    logic [ROW_CNT_W-1:0]  w_rows;
    logic                  w_legal;
    logic [BEAT_CNT_W-1:0] w_last_beat;
    logic [ROW_CNT_W-1:0]  w_last_row;

    // In IDLE the decoder judges the incoming code; afterwards the latched one.
    assign w_res_sel = (r_state == IDLE) ? res_in : r_res_q;

    mask_res_decode #(
        .STEPS_SEL0 (STEPS_SEL0),
        .STEPS_SEL1 (STEPS_SEL1),
        .STEPS_SEL2 (STEPS_SEL2),
        .ROWS_SEL0  (ROWS_SEL0),
        .ROWS_SEL1  (ROWS_SEL1),
        .ROWS_SEL2  (ROWS_SEL2),
        .ROW_CNT_W  (ROW_CNT_W)
    ) u_decode (
        .i_res   (w_res_sel),
        .o_steps (w_steps),
        .o_rows  (w_rows),
        .o_legal (w_legal)
    );

    assign w_last_beat = w_steps - BEAT_CNT_W'(1);
    assign w_last_row  = w_rows - ROW_CNT_W'(1);

    // Abort masks every handshake and strobe in the cycle it is raised.
    assign row_ready  = (r_state == WAIT_ROW) && !abort;
    assign ser_load   = row_ready && row_valid;
    assign out_valid  = (r_state == STREAM) && !abort;
    assign ser_next   = out_valid && out_ready;
    assign frame_done = (r_state == FRAME_END) && !abort;
    assign busy       = (r_state != IDLE);
    assign ser_res    = r_res_q;
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_res_q    <= 2'b00;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_err      <= 1'b0;
        end else if (abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            r_res_q   <= res_in;
                            r_row_cnt <= '0;
                            r_err     <= 1'b0;
                            r_state   <= WAIT_ROW;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                WAIT_ROW: begin
                    if (ser_load) begin
                        r_beat_cnt <= '0;
                        r_state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (ser_next) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                        if (r_beat_cnt == w_last_beat) begin
                            r_state <= ROW_END;
                        end
                    end
                end
                ROW_END: begin
                    // Serializer must agree that the row is fully shifted out.
                    if (!ser_done) begin
                        r_err <= 1'b1;
                    end
                    if (r_row_cnt == w_last_row) begin
                        r_state <= FRAME_END;
                    end else begin
                        r_row_cnt <= r_row_cnt + ROW_CNT_W'(1);
                        r_state   <= WAIT_ROW;
                    end
                end
                FRAME_END: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_serializer_ctrl.sv
// Bench for mask_serializer_ctrl with a behavioural serializer and a per-row
// beat scoreboard.
`timescale 1ns/1ps
module tb_mask_serializer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] res_in = 2'b00;
    logic       abort = 1'b0;
    logic       row_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       row_ready, ser_load, ser_next, out_valid, busy, frame_done, err;
    logic [1:0] ser_res;
    logic       ser_done;

    int checks = 0;
    int errors = 0;
    int q_exp[$];

    mask_serializer_ctrl #(
        .ROWS_SEL0 (2),
        .ROWS_SEL1 (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .res_in     (res_in),
        .abort      (abort),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .ser_load   (ser_load),
        .ser_next   (ser_next),
        .ser_res    (ser_res),
        .ser_done   (ser_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic int steps_of(input logic [1:0] r);
        case (r)
            2'b00:   return 16;
            2'b01:   return 32;
            2'b10:   return 54;
            default: return 0;
        endcase
    endfunction

    // Behavioural serializer: done once it has shifted a full row.
    int sm_cnt = 0;
    int sm_steps = 0;
    logic sm_force = 1'b0;
    always @(posedge clk) begin
        if (ser_load) begin
            sm_cnt   <= 0;
            sm_steps <= steps_of(ser_res);
        end else if (ser_next) begin
            sm_cnt <= sm_cnt + 1;
        end
    end
    assign ser_done = !sm_force && (sm_cnt == sm_steps);

    // Monitor: event counters and beats observed per completed row.
    int n_load = 0, n_next = 0, n_fd = 0, n_viol = 0, n_rows = 0, cur_beats = 0;
    int obs_beats[256];
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
        end else begin
            if (ser_load) n_load <= n_load + 1;
            if (ser_next) n_next <= n_next + 1;
            if (frame_done) n_fd <= n_fd + 1;
            if ((ser_load && ser_next) || (ser_next && !(out_valid && out_ready)))
                n_viol <= n_viol + 1;
            if (ser_load) cur_beats <= 0;
            else if (ser_next) cur_beats <= cur_beats + 1;
            if (prev_ov && !out_valid && busy && !abort && !row_ready && !frame_done) begin
                obs_beats[n_rows % 256] <= cur_beats;
                n_rows <= n_rows + 1;
            end
            prev_ov <= out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_valid = 1'b0;
        out_ready = 1'b0; res_in = 2'b00; sm_force = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic begin_frame(input logic [1:0] res);
        res_in = res;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_fd(input int budget, output int cyc);
        cyc = 0;
        while (!frame_done && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({row_ready, ser_load, ser_next, out_valid, frame_done} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {row_ready, ser_load, ser_next, out_valid, frame_done}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (ser_res !== 2'b00) begin errors++; $display("FAIL reset_ser_res: got %b expected 00", ser_res); end
        do_reset();
    endtask

    task automatic test_basic();
        int cyc, l0, x0, f0, r0;
        l0 = n_load; x0 = n_next; f0 = n_fd; r0 = n_rows;
        repeat (2) q_exp.push_back(16);
        row_valid = 1'b1; out_ready = 1'b1;
        begin_frame(2'b00);
        wait_fd(200, cyc);
        checks++; if (cyc !== 36) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 36", cyc); end
        tick();
        checks++; if (n_load - l0 !== 2) begin errors++; $display("FAIL basic_loads: got %0d expected 2", n_load - l0); end
        checks++; if (n_next - x0 !== 32) begin errors++; $display("FAIL basic_nexts: got %0d expected 32", n_next - x0); end
        checks++; if (n_fd - f0 !== 1) begin errors++; $display("FAIL basic_frame_done: got %0d expected 1", n_fd - f0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy %b expected 0", busy); end
        checks++; if (n_rows - r0 !== 2) begin errors++; $display("FAIL basic_rows: got %0d expected 2", n_rows - r0); end
        for (int i = 0; i < 2; i++) begin
            int e;
            e = q_exp.pop_front();
            checks++; if (obs_beats[(r0 + i) % 256] !== e) begin errors++;
                $display("FAIL basic_row_beats[%0d]: got %0d expected %0d", i, obs_beats[(r0 + i) % 256], e); end
        end
    endtask

    task automatic test_backpressure();
        int cyc, x0, v0, r0;
        logic bad_res;
        x0 = n_next; v0 = n_viol; r0 = n_rows; bad_res = 1'b0;
        repeat (3) q_exp.push_back(32);
        row_valid = 1'b1; out_ready = 1'b0;
        begin_frame(2'b01);
        cyc = 0;
        while (!frame_done && cyc < 3000) begin
            out_ready = ~out_ready;
            start = (cyc == 20);
            if (cyc == 20) res_in = 2'b00;
            tick();
            cyc++;
            if (ser_res !== 2'b01) bad_res = 1'b1;
        end
        start = 1'b0; out_ready = 1'b1;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_frame_done: got %b expected 1 after %0d cycles", frame_done, cyc); end
        tick();
        checks++; if (bad_res !== 1'b0) begin errors++; $display("FAIL bp_ser_res_held: got change, expected ser_res 01 throughout"); end
        checks++; if (n_next - x0 !== 96) begin errors++; $display("FAIL bp_nexts: got %0d expected 96", n_next - x0); end
        checks++; if (n_viol - v0 !== 0) begin errors++; $display("FAIL bp_strobe_rules: got %0d violations expected 0", n_viol - v0); end
        checks++; if (n_rows - r0 !== 3) begin errors++; $display("FAIL bp_rows: got %0d expected 3", n_rows - r0); end
        for (int i = 0; i < 3; i++) begin
            int e;
            e = q_exp.pop_front();
            checks++; if (obs_beats[(r0 + i) % 256] !== e) begin errors++;
                $display("FAIL bp_row_beats[%0d]: got %0d expected %0d", i, obs_beats[(r0 + i) % 256], e); end
        end
    endtask

    task automatic test_illegal();
        int cyc, l0, x0;
        l0 = n_load; x0 = n_next;
        row_valid = 1'b1; out_ready = 1'b1;
        begin_frame(2'b11);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
        repeat (5) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy: got %b expected 0", busy); end
        checks++; if ((n_load - l0) + (n_next - x0) !== 0) begin errors++;
            $display("FAIL illegal_strobes: got %0d strobes expected 0", (n_load - l0) + (n_next - x0)); end
        begin_frame(2'b00);
        checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL illegal_restart: got busy,err=%b expected 10", {busy, err}); end
        wait_fd(200, cyc);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL illegal_restart_done: got %b expected 1", frame_done); end
        tick();
    endtask

    task automatic test_done_mismatch();
        int cyc, r0;
        row_valid = 1'b1; out_ready = 1'b1;
        sm_force = 1'b1;
        begin_frame(2'b00);
        r0 = n_rows; cyc = 0;
        while (n_rows == r0 && cyc < 100) begin
            tick();
            cyc++;
        end
        sm_force = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mismatch_err_row0: got %b expected 1", err); end
        wait_fd(100, cyc);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mismatch_frame_done: got %b expected 1", frame_done); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mismatch_err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_abort();
        int cyc, r0, x0, f0;
        logic e0;
        row_valid = 1'b1; out_ready = 1'b1;
        begin_frame(2'b10);
        q_exp.push_back(54);
        r0 = n_rows; cyc = 0;
        while (!(n_rows == r0 + 1 && cur_beats == 10) && cyc < 500) begin
            tick();
            cyc++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_reach_beat10: got out_valid %b expected 1", out_valid); end
        abort = 1'b1;
        #1;
        checks++; if ({ser_load, ser_next} !== 2'b00) begin errors++; $display("FAIL abort_cycle_strobes: got %b expected 00", {ser_load, ser_next}); end
        x0 = n_next; f0 = n_fd; e0 = err;
        tick();
        abort = 1'b0;
        checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL abort_idle: got busy,out_valid=%b expected 00", {busy, out_valid}); end
        repeat (60) tick();
        checks++; if (n_next !== x0) begin errors++; $display("FAIL abort_no_next: got %0d extra expected 0", n_next - x0); end
        checks++; if (n_fd !== f0) begin errors++; $display("FAIL abort_no_frame_done: got %0d expected 0", n_fd - f0); end
        checks++; if (err !== e0) begin errors++; $display("FAIL abort_err_unchanged: got %b expected %b", err, e0); end
        begin
            int e;
            e = q_exp.pop_front();
            checks++; if (obs_beats[r0 % 256] !== e) begin errors++; $display("FAIL abort_row0_beats: got %0d expected %0d", obs_beats[r0 % 256], e); end
        end
    endtask

    task automatic test_row_stall();
        int cyc, l0;
        logic bad;
        l0 = n_load; bad = 1'b0;
        row_valid = 1'b0; out_ready = 1'b1;
        begin_frame(2'b00);
        repeat (20) begin
            if (ser_load !== 1'b0 || ser_next !== 1'b0 || row_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_hold: got strobe or row_ready drop, expected load/next 0 and row_ready 1"); end
        row_valid = 1'b1;
        #1;
        checks++; if (ser_load !== 1'b1) begin errors++; $display("FAIL stall_load_same_cycle: got %b expected 1", ser_load); end
        wait_fd(200, cyc);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stall_frame_done: got %b expected 1", frame_done); end
        tick();
        checks++; if (n_load - l0 !== 2) begin errors++; $display("FAIL stall_loads: got %0d expected 2", n_load - l0); end
    endtask

    task automatic test_async_reset();
        row_valid = 1'b1; out_ready = 1'b1;
        begin_frame(2'b01);
        repeat (5) tick();
        checks++; if ({out_valid, ser_res} !== 3'b101) begin errors++; $display("FAIL areset_pre: got %b expected 101", {out_valid, ser_res}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, out_valid, row_ready, ser_next} !== 4'b0) begin errors++;
            $display("FAIL areset_outputs: got %b expected 0000", {busy, out_valid, row_ready, ser_next}); end
        checks++; if (ser_res !== 2'b00) begin errors++; $display("FAIL areset_ser_res: got %b expected 00", ser_res); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_done_mismatch();
        test_abort();
        test_row_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule
